sw_txbuf_mflow: RTL and testbench

- Parametrised multi-flow software TX buffer, the successor to the fixed two-side TX buffer.
- Software writes frame data words per flow over a simple valid/ready write port, then commits each frame by flow and byte length.
- Each flow drains committed frames independently on its own FrameLink output.
- Sits between the internal-bus write endpoint and the per-flow FrameLink TX paths. Adds per-flow free-space reporting and commit error detection.

---
 rtl/sw_txbuf_mflow_if.sv | 41 ++++
 rtl/sw_txbuf_mflow.sv | 179 +++++++++++++++++
 tb/tb_sw_txbuf_mflow.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/sw_txbuf_mflow_if.sv
// Software write/commit port and per-flow FrameLink TX bundle for sw_txbuf_mflow.
// Widths follow the buffer parameters so that slices line up per flow.
interface sw_txbuf_mflow_if #(
  parameter int DATA_WIDTH = 64,
  parameter int FLOWS      = 4,
  parameter int FLOW_DEPTH = 512,
  parameter int LEN_WIDTH  = 16
);
  localparam int FW   = (FLOWS > 1) ? $clog2(FLOWS) : 1;
  localparam int RW   = (DATA_WIDTH > 8) ? $clog2(DATA_WIDTH / 8) : 1;
  localparam int CNTW = $clog2(FLOW_DEPTH) + 1;

  logic [FW-1:0]              WR_FLOW;
  logic [DATA_WIDTH-1:0]      WR_DATA;
  logic                       WR_VLD;
  logic                       WR_RDY;
  logic [FW-1:0]              CMT_FLOW;
  logic [LEN_WIDTH-1:0]       CMT_LEN;
  logic                       CMT_VLD;
  logic                       CMT_RDY;
  logic                       CMT_ERR;
  logic [FLOWS*DATA_WIDTH-1:0] TX_DATA;
  logic [FLOWS*RW-1:0]        TX_REM;
  logic [FLOWS-1:0]           TX_SOF_N;
  logic [FLOWS-1:0]           TX_EOF_N;
  logic [FLOWS-1:0]           TX_SRC_RDY_N;
  logic [FLOWS-1:0]           TX_DST_RDY_N;
  logic [FLOWS*CNTW-1:0]      FREE_WORDS;

  modport master (
    output WR_FLOW, WR_DATA, WR_VLD, CMT_FLOW, CMT_LEN, CMT_VLD, TX_DST_RDY_N,
    input  WR_RDY, CMT_RDY, CMT_ERR, TX_DATA, TX_REM, TX_SOF_N, TX_EOF_N,
           TX_SRC_RDY_N, FREE_WORDS
  );

  modport slave (
    input  WR_FLOW, WR_DATA, WR_VLD, CMT_FLOW, CMT_LEN, CMT_VLD, TX_DST_RDY_N,
    output WR_RDY, CMT_RDY, CMT_ERR, TX_DATA, TX_REM, TX_SOF_N, TX_EOF_N,
           TX_SRC_RDY_N, FREE_WORDS
  );
endinterface

// File: rtl/sw_txbuf_mflow.sv
// Multi-flow software TX buffer: per-flow ring buffer filled by word writes,
// frames released by length commits and drained on independent FrameLink outputs.
module sw_txbuf_mflow #(
  parameter int DATA_WIDTH     = 64,
  parameter int FLOWS          = 4,
  parameter int FLOW_DEPTH     = 512,
  parameter int LEN_FIFO_DEPTH = 8,
  parameter int LEN_WIDTH      = 16
) (
  input logic           CLK,
  input logic           RESET,
  sw_txbuf_mflow_if.slave s
);
  localparam int BPW  = DATA_WIDTH / 8;
  localparam int BSH  = (BPW > 1) ? $clog2(BPW) : 0;
  localparam int RW   = (BPW > 1) ? $clog2(BPW) : 1;
  localparam int FW   = (FLOWS > 1) ? $clog2(FLOWS) : 1;
  localparam int AW   = $clog2(FLOW_DEPTH);
  localparam int CNTW = AW + 1;
  localparam int LAW  = (LEN_FIFO_DEPTH > 1) ? $clog2(LEN_FIFO_DEPTH) : 1;
  localparam int WCW  = LEN_WIDTH + 1;
  localparam int CMPW = (WCW > CNTW) ? WCW : CNTW;

  typedef enum logic [1:0] {IDLE, LOAD, SEND} state_t;

  logic             up, wr_rdy, cmt_rdy, wr_acc, cmt_acc, cmt_err;
  logic [CNTW-1:0]  free_w [FLOWS];
  logic [FLOWS-1:0] lf_full, cmt_bad;
  logic [WCW-1:0]   cmt_words;

  assign cmt_words = (WCW'(s.CMT_LEN) + WCW'(BPW - 1)) >> BSH;

  // Ready flags stay low until the first clock after reset release.
  always_comb begin
    wr_rdy  = 1'b0;
    cmt_rdy = 1'b0;
    for (int unsigned f = 0; f < FLOWS; f++) begin
      if (s.WR_FLOW == FW'(f))  wr_rdy  = up && (free_w[f] != '0);
      if (s.CMT_FLOW == FW'(f)) cmt_rdy = up && !lf_full[f];
    end
  end

  assign wr_acc    = s.WR_VLD && wr_rdy;
  assign cmt_acc   = s.CMT_VLD && cmt_rdy;
  assign s.WR_RDY  = wr_rdy;
  assign s.CMT_RDY = cmt_rdy;
  assign s.CMT_ERR = cmt_err;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      up      <= 1'b0;
      cmt_err <= 1'b0;
    end else begin
      up      <= 1'b1;
      cmt_err <= |cmt_bad;
    end
  end

  for (genvar g = 0; g < FLOWS; g++) begin : g_flow
    logic [DATA_WIDTH-1:0] mem [FLOW_DEPTH];
    logic [LEN_WIDTH-1:0]  lf [2**LAW];
    logic [AW-1:0]         wr_ptr, rd_ptr, rd_nx1, rd_nx2;
    logic [CNTW-1:0]       ucnt, ucnt_nxt, free;
    logic [LAW-1:0]        lf_wp, lf_rp;
    logic [LAW:0]          lf_cnt;
    logic [LEN_WIDTH-1:0]  cur_len;
    logic [WCW-1:0]        cur_words, left;
    logic [RW-1:0]         rem_last, tx_rem;
    logic [DATA_WIDTH-1:0] rdata, tx_data;
    logic                  sof_n, eof_n, src_n;
    logic                  wr_sel, cmt_sel, cmt_ok, push, pop, xfer;
    state_t                state;

    assign wr_sel     = wr_acc && (s.WR_FLOW == FW'(g));
    assign cmt_sel    = cmt_acc && (s.CMT_FLOW == FW'(g));
    assign cmt_ok     = (s.CMT_LEN != '0) && (CMPW'(cmt_words) <= CMPW'(ucnt));
    assign push       = cmt_sel && cmt_ok;
    assign cmt_bad[g] = cmt_sel && !cmt_ok;
    assign pop        = (state == IDLE) && (lf_cnt != '0);
    assign xfer       = (state == SEND) && !s.TX_DST_RDY_N[g];
    assign lf_full[g] = (lf_cnt == (LAW + 1)'(LEN_FIFO_DEPTH));
    assign free_w[g]  = free;
    assign cur_len    = lf[lf_rp];
    assign cur_words  = (WCW'(cur_len) + WCW'(BPW - 1)) >> BSH;
    assign rd_nx1     = rd_ptr + AW'(1);
    assign rd_nx2     = rd_ptr + AW'(2);

    // Commit is judged against the count before this cycle's write lands.
    always_comb begin
      ucnt_nxt = ucnt;
      if (wr_sel) ucnt_nxt = ucnt_nxt + CNTW'(1);
      if (push)   ucnt_nxt = ucnt_nxt - CNTW'(cmt_words);
    end

    always_ff @(posedge CLK) begin
      if (wr_sel) mem[wr_ptr] <= s.WR_DATA;
      if (push)   lf[lf_wp]   <= s.CMT_LEN;
    end

    // rdata always holds the word after the one on TX_DATA, so a transfer
    // can reload the output and fetch rd_ptr+2 in the same edge.
    always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        ucnt     <= '0;
        free     <= CNTW'(FLOW_DEPTH);
        lf_wp    <= '0;
        lf_rp    <= '0;
        lf_cnt   <= '0;
        left     <= '0;
        rem_last <= '0;
        rdata    <= '0;
        tx_data  <= '0;
        tx_rem   <= '0;
        sof_n    <= 1'b1;
        eof_n    <= 1'b1;
        src_n    <= 1'b1;
        state    <= IDLE;
      end else begin
        if (wr_sel) wr_ptr <= wr_ptr + AW'(1);
        ucnt <= ucnt_nxt;
        case ({wr_sel, xfer})
          2'b10:   free <= free - CNTW'(1);
          2'b01:   free <= free + CNTW'(1);
          default: ;
        endcase
        if (push) lf_wp <= lf_wp + LAW'(1);
        if (pop)  lf_rp <= lf_rp + LAW'(1);
        case ({push, pop})
          2'b10:   lf_cnt <= lf_cnt + (LAW + 1)'(1);
          2'b01:   lf_cnt <= lf_cnt - (LAW + 1)'(1);
          default: ;
        endcase
        case (state)
          IDLE: if (pop) begin
            rdata    <= mem[rd_ptr];
            left     <= cur_words;
            rem_last <= (BSH == 0) ? '0 : RW'(cur_len - LEN_WIDTH'(1));
            state    <= LOAD;
          end
          LOAD: begin
            tx_data <= rdata;
            rdata   <= mem[rd_nx1];
            src_n   <= 1'b0;
            sof_n   <= 1'b0;
            eof_n   <= (left != WCW'(1));
            tx_rem  <= (left == WCW'(1)) ? rem_last : '0;
            state   <= SEND;
          end
          SEND: if (xfer) begin
            rd_ptr <= rd_nx1;
            left   <= left - WCW'(1);
            sof_n  <= 1'b1;
            if (left == WCW'(1)) begin
              src_n  <= 1'b1;
              eof_n  <= 1'b1;
              tx_rem <= '0;
              state  <= IDLE;
            end else begin
              tx_data <= rdata;
              rdata   <= mem[rd_nx2];
              eof_n   <= (left != WCW'(2));
              tx_rem  <= (left == WCW'(2)) ? rem_last : '0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end

    assign s.TX_DATA[g*DATA_WIDTH +: DATA_WIDTH] = tx_data;
    assign s.TX_REM[g*RW +: RW]                  = tx_rem;
    assign s.TX_SOF_N[g]                         = sof_n;
    assign s.TX_EOF_N[g]                         = eof_n;
    assign s.TX_SRC_RDY_N[g]                     = src_n;
    assign s.FREE_WORDS[g*CNTW +: CNTW]          = free;
  end
endmodule

// File: tb/tb_sw_txbuf_mflow.sv
// Directed bench for sw_txbuf_mflow: table of write/commit/drain vectors plus
// hand sequences for buffer fill and wrap, per-flow stall and mid-frame reset.
module tb_sw_txbuf_mflow;
  localparam int DW    = 64;
  localparam int NF    = 4;
  localparam int DEPTH = 512;
  localparam int LW    = 16;
  localparam int CW    = 10;
  localparam int RW    = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sw_txbuf_mflow_if #(.DATA_WIDTH(DW), .FLOWS(NF), .FLOW_DEPTH(DEPTH), .LEN_WIDTH(LW)) ifc ();

  sw_txbuf_mflow #(
    .DATA_WIDTH(DW), .FLOWS(NF), .FLOW_DEPTH(DEPTH), .LEN_FIFO_DEPTH(8), .LEN_WIDTH(LW)
  ) dut (
    .CLK  (clk),
    .RESET(rst_n),
    .s    (ifc)
  );

  int tests  = 0;
  int failed = 0;
  logic [63:0] mdl [NF][1024];
  int head [NF];
  int tail [NF];
  int unsigned seq = 0;

  typedef struct {
    int   flow;
    int   nwr;
    int   len;
    logic err;
    int   words;
    int   rem;
  } vec_t;
  vec_t vecs [10];

  function automatic logic src_n(input int f);
    return ifc.TX_SRC_RDY_N[f];
  endfunction
  function automatic logic [63:0] txd(input int f);
    return ifc.TX_DATA[f*DW +: DW];
  endfunction
  function automatic logic [RW-1:0] txrem(input int f);
    return ifc.TX_REM[f*RW +: RW];
  endfunction
  function automatic logic [CW-1:0] freew(input int f);
    return ifc.FREE_WORDS[f*CW +: CW];
  endfunction
  function automatic int pending(input int f);
    return tail[f] - head[f];
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic wr_words(input int f, input int n);
    for (int i = 0; i < n; i++) begin
      ifc.WR_FLOW = 2'(f);
      ifc.WR_DATA = {4'(f), 28'h5a5a5a5, 32'(seq)};
      ifc.WR_VLD  = 1'b1;
      #1;
      chk($sformatf("f%0d wr_rdy", f), 64'(ifc.WR_RDY), 64'd1);
      mdl[f][tail[f] % 1024] = ifc.WR_DATA;
      tail[f]++;
      seq++;
      @(posedge clk); #1;
    end
    ifc.WR_VLD = 1'b0;
  endtask

  task automatic do_commit(input int f, input int len);
    ifc.CMT_FLOW = 2'(f);
    ifc.CMT_LEN  = 16'(len);
    ifc.CMT_VLD  = 1'b1;
    #1;
    chk($sformatf("f%0d cmt_rdy", f), 64'(ifc.CMT_RDY), 64'd1);
    @(posedge clk); #1;
    ifc.CMT_VLD = 1'b0;
  endtask

  task automatic wait_latency(input int f);
    int lat = 0;
    while (src_n(f) && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    chk($sformatf("f%0d first-word latency", f), 64'(lat), 64'd2);
  endtask

  task automatic rx_frame(input int f, input int nw, input int rem_exp);
    int got = 0;
    int guard = 0;
    while (got < nw && guard < 1000) begin
      if (!src_n(f)) begin
        if (!ifc.TX_DST_RDY_N[f]) begin
          chk($sformatf("f%0d data w%0d", f, got), txd(f), mdl[f][head[f] % 1024]);
          chk($sformatf("f%0d sof_n w%0d", f, got), 64'(ifc.TX_SOF_N[f]), (got == 0) ? 64'd0 : 64'd1);
          chk($sformatf("f%0d eof_n w%0d", f, got), 64'(ifc.TX_EOF_N[f]), (got == nw - 1) ? 64'd0 : 64'd1);
          chk($sformatf("f%0d rem w%0d", f, got), 64'(txrem(f)), (got == nw - 1) ? 64'(rem_exp) : 64'd0);
          head[f]++;
          got++;
        end
      end else if (got > 0) begin
        chk($sformatf("f%0d gap before w%0d", f, got), 64'(src_n(f)), 64'd0);
      end
      @(posedge clk); #1;
      guard++;
    end
    if (got < nw) chk($sformatf("f%0d frame timeout", f), 64'(got), 64'(nw));
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, " src_rdy_n"}, 64'(ifc.TX_SRC_RDY_N), 64'hf);
    chk({tag, " sof_n"}, 64'(ifc.TX_SOF_N), 64'hf);
    chk({tag, " eof_n"}, 64'(ifc.TX_EOF_N), 64'hf);
    chk({tag, " tx_data"}, (ifc.TX_DATA == '0) ? 64'd0 : 64'd1, 64'd0);
    chk({tag, " tx_rem"}, 64'(ifc.TX_REM), 64'd0);
    chk({tag, " wr_rdy"}, 64'(ifc.WR_RDY), 64'd0);
    chk({tag, " cmt_rdy"}, 64'(ifc.CMT_RDY), 64'd0);
    chk({tag, " cmt_err"}, 64'(ifc.CMT_ERR), 64'd0);
    for (int f = 0; f < NF; f++) chk($sformatf("%s free f%0d", tag, f), 64'(freew(f)), 64'd512);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int f;
    int stale;
    logic [63:0] held;

    // flow, writes, len, err, words, rem
    vecs[0] = '{0, 3, 20, 1'b0, 3, 3};
    vecs[1] = '{0, 1, 1,  1'b0, 1, 0};
    vecs[2] = '{3, 2, 24, 1'b1, 0, 0};
    vecs[3] = '{3, 0, 0,  1'b1, 0, 0};
    vecs[4] = '{3, 1, 24, 1'b0, 3, 7};
    vecs[5] = '{1, 2, 16, 1'b0, 2, 7};
    vecs[6] = '{1, 1, 9,  1'b1, 0, 0};
    vecs[7] = '{1, 1, 9,  1'b0, 2, 0};
    vecs[8] = '{2, 4, 25, 1'b0, 4, 0};
    vecs[9] = '{2, 1, 8,  1'b0, 1, 7};

    for (int i = 0; i < NF; i++) begin head[i] = 0; tail[i] = 0; end
    ifc.WR_FLOW = '0; ifc.WR_DATA = '0; ifc.WR_VLD = 1'b0;
    ifc.CMT_FLOW = '0; ifc.CMT_LEN = '0; ifc.CMT_VLD = 1'b0;
    ifc.TX_DST_RDY_N = '0;

    #12;
    chk_reset_state("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int v = 0; v < 10; v++) begin
      f = vecs[v].flow;
      wr_words(f, vecs[v].nwr);
      chk($sformatf("v%0d free after writes", v), 64'(freew(f)), 64'(512 - pending(f)));
      do_commit(f, vecs[v].len);
      chk($sformatf("v%0d cmt_err", v), 64'(ifc.CMT_ERR), 64'(vecs[v].err));
      if (vecs[v].err) begin
        @(posedge clk); #1;
        chk($sformatf("v%0d cmt_err one cycle", v), 64'(ifc.CMT_ERR), 64'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk($sformatf("v%0d no output", v), 64'(src_n(f)), 64'd1);
        chk($sformatf("v%0d free unchanged", v), 64'(freew(f)), 64'(512 - pending(f)));
      end else begin
        wait_latency(f);
        rx_frame(f, vecs[v].words, vecs[v].rem);
        chk($sformatf("v%0d free after drain", v), 64'(freew(f)), 64'(512 - pending(f)));
      end
    end

    // Fill flow 2 from a non-zero pointer so the 512-word frame wraps.
    wr_words(2, 512);
    chk("fill free f2", 64'(freew(2)), 64'd0);
    ifc.WR_FLOW = 2'd2; #1;
    chk("fill wr_rdy f2", 64'(ifc.WR_RDY), 64'd0);
    ifc.WR_DATA = 64'hdead_beef_dead_beef;
    ifc.WR_VLD = 1'b1;
    @(posedge clk); #1;
    ifc.WR_VLD = 1'b0;
    chk("fill ignored write free f2", 64'(freew(2)), 64'd0);
    for (int g = 0; g < NF; g++) begin
      if (g != 2) begin
        ifc.WR_FLOW = 2'(g); #1;
        chk($sformatf("fill wr_rdy f%0d", g), 64'(ifc.WR_RDY), 64'd1);
      end
    end
    do_commit(2, 4096);
    chk("fill cmt_err", 64'(ifc.CMT_ERR), 64'd0);
    wait_latency(2);
    rx_frame(2, 512, 7);
    chk("fill free after drain", 64'(freew(2)), 64'd512);

    // Flow 0 stalled while flow 1 drains.
    ifc.TX_DST_RDY_N[0] = 1'b1;
    wr_words(0, 4);
    wr_words(1, 3);
    do_commit(0, 32);
    do_commit(1, 24);
    rx_frame(1, 3, 7);
    chk("stall f1 free", 64'(freew(1)), 64'd512);
    held = txd(0);
    repeat (3) begin @(posedge clk); #1; end
    chk("stall f0 valid", 64'(src_n(0)), 64'd0);
    chk("stall f0 sof_n", 64'(ifc.TX_SOF_N[0]), 64'd0);
    chk("stall f0 held data", txd(0), held);
    chk("stall f0 first word", txd(0), mdl[0][head[0] % 1024]);
    chk("stall f0 free", 64'(freew(0)), 64'd508);
    ifc.TX_DST_RDY_N[0] = 1'b0;
    rx_frame(0, 4, 7);
    chk("stall f0 free after drain", 64'(freew(0)), 64'd512);

    // Reset in the middle of a flow 3 frame.
    wr_words(3, 6);
    do_commit(3, 48);
    wait_latency(3);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("mid-frame f3 busy", 64'(src_n(3)), 64'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_state("mid-frame reset");
    for (int i = 0; i < NF; i++) begin head[i] = 0; tail[i] = 0; end
    @(posedge clk); #1;
    rst_n = 1'b1;
    stale = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (ifc.TX_SRC_RDY_N != 4'hf) stale++;
    end
    chk("no stale frame after reset", 64'(stale), 64'd0);
    wr_words(3, 1);
    do_commit(3, 5);
    chk("post-reset cmt_err", 64'(ifc.CMT_ERR), 64'd0);
    wait_latency(3);
    rx_frame(3, 1, 4);
    chk("post-reset free f3", 64'(freew(3)), 64'd512);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
